clock_period_meter: RTL



---
 rtl/clock_meter_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/clock_period_meter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg: state encoding and counter defaults shared by the clock period meter.
package clock_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 32;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an asynchronous input with one-cycle rise/fall strobes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period/high time of a slow asynchronous clock in clkin cycles.
// Optional min/max period tracking is built when CLOCK_METER_MINMAX_EN is defined.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             meas_clk,
    input  logic             enable,
    output logic             edge_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             timeout
`ifdef CLOCK_METER_MINMAX_EN
    ,
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t state, state_nx;
    logic level_unused, rise, fall;
    logic [CNT_W-1:0] cnt, high_cap;
    logic tmo_hit, publish, load;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clkin),
        .rst_n(rst_n),
        .din  (meas_clk),
        .level(level_unused),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tmo_hit  = 1'b0;
        publish  = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = ARM;
                ARM:     state_nx = rise ? MEASURE : ARM;
                MEASURE: begin
                    // Timeout takes precedence over a rise landing on the same count.
                    if (cnt == TMO) begin
                        tmo_hit  = 1'b1;
                        state_nx = ARM;
                    end else begin
                        publish = rise;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign load = publish && (!period_valid || period_ready);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            high_cap     <= '0;
            edge_tick    <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            edge_tick <= rise;
            // Every rise that keeps us measuring restarts the count at 1.
            if (state_nx != MEASURE) cnt <= '0;
            else if (rise)           cnt <= CNT_W'(1);
            else                     cnt <= cnt + CNT_W'(1);
            if (state_nx != MEASURE) high_cap <= '0;
            else if (fall)           high_cap <= cnt;
            if (load) begin
                period       <= cnt;
                high_time    <= high_cap;
                period_valid <= 1'b1;
            end else if (period_ready) begin
                period_valid <= 1'b0;
            end
            if (!enable) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if (publish && !load) overrun <= 1'b1;
                if (tmo_hit)                   timeout <= 1'b1;
                else if (state == ARM && rise) timeout <= 1'b0;
            end
        end
    end

`ifdef CLOCK_METER_MINMAX_EN
    // Dropped results still count toward the extremes; a clear seeds both from a coincident result.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            period_min <= '1;
            period_max <= '0;
        end else if (publish) begin
            period_min <= (minmax_clr || cnt < period_min) ? cnt : period_min;
            period_max <= (minmax_clr || cnt > period_max) ? cnt : period_max;
        end else if (minmax_clr) begin
            period_min <= '1;
            period_max <= '0;
        end
    end
`endif

endmodule
